mem_stage: RTL
==============

# mem_stage

Memory stage of the five-stage ARM pipeline, directly downstream of `EXE`. It consumes the execute results (`ALU_res`, `val_rm`, `dest`) and the control bits (`WB_EN`, `MEM_R`, `MEM_W`). It performs loads and stores against a word-addressed data memory with a configurable multi-cycle latency, and registers the results into the MEM/WB boundary for write-back. While an access is in flight it drops `ready`; the top level uses the inverse of `ready` as the freeze for all upstream stages.

## Interface
Clock `clk`, single domain. Reset `rst`: asynchronous, active-high.

Parameters:
- `WAIT_CYCLES`, default 4: total cycles per load or store, including the issue cycle. Must be ≥1.
- `DEPTH`, default 64: data memory size in 32-bit words. Must be a power of two.
- `ADDR_BASE`, default 1024: byte address that maps to word 0.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `WB_EN`  in  1  write-back enable from EXE
- `MEM_R`  in  1  load request
- `MEM_W`  in  1  store request
- `ALU_res`  in  32  effective byte address, or ALU result for non-memory instructions
- `val_rm`  in  32  store data
- `dest`  in  4  destination register
- `ready`  out  1  current instruction completes this cycle; upstream freezes while low
- `WB_EN_out`  out  1  registered write-back enable
- `MEM_R_out`  out  1  registered load flag (WB mux select)
- `ALU_res_out`  out  32  registered ALU result
- `mem_data_out`  out  32  registered load data
- `dest_out`  out  4  registered destination

## Operation
FSM states and transitions:
- `IDLE`: if `MEM_R|MEM_W` and `WAIT_CYCLES>1`, drive `ready=0`, set `cnt<=1` and go to `BUSY`. Otherwise drive `ready=1`.
- `BUSY`: `ready=(cnt==WAIT_CYCLES-1)`. When ready, go to `IDLE` and clear `cnt`. Otherwise increment `cnt`.
- `WAIT_CYCLES==1`: the FSM never leaves `IDLE`, and every instruction has `ready=1`.

Address and data rules:
- Word index = `(ALU_res - ADDR_BASE) >> 2`. The low two address bits are ignored.
- Out of range (`ALU_res < ADDR_BASE` or index ≥ `DEPTH`): stores are dropped and loads return 0.
- Store: the array write happens at the clock edge that ends the `ready=1` cycle.
- Load: asynchronous array read, sampled into `mem_data_out` at that same edge.
- `MEM_R` and `MEM_W` both high is illegal. `MEM_W` takes priority and `mem_data_out` loads 0.

Output register:
- On each edge where `ready=1`, capture all inputs.
- On each edge where `ready=0`, capture a bubble: `WB_EN_out=0`, `MEM_R_out=0`, other fields unchanged. This prevents a duplicate write-back.

Reset:
- All outputs reset to 0 except `ready`, which is combinational and reads 1 when inputs are idle. State resets to `IDLE` and `cnt` to 0.
- Memory contents are not cleared by reset.
- Reset during `BUSY` abandons the access; a pending store is not written.

## Timing
- Non-memory instruction: one cycle, `ready=1`, results visible on outputs the cycle after presentation.
- Memory instruction presented in cycle t: `ready=0` in cycles t..t+W-2 and `ready=1` in cycle t+W-1. Outputs are valid from t+W. Bubbles are emitted in cycles t+1..t+W-1.
- Upstream holds all inputs stable while `ready=0`. The block does not re-latch them.
- Back-to-back memory instructions: the second starts in the cycle after the first's `ready=1`, with no extra idle cycle. Throughput is one memory op per W cycles.
- Store followed by load to the same address returns the new data, because the write completes before the load's sample edge.

## Structure
- Shared package `arm_pkg` holds the FSM state enum (`IDLE`, `BUSY`) and the default `ADDR_BASE` constant.
- Sub-module `data_mem` (parameter `DEPTH`) contains the array, with synchronous write, asynchronous read and range checking.
- The FSM, counter and MEM/WB register live in `mem_stage`.

## Test plan
All scenarios use `WAIT_CYCLES=4`.
- **ALU op:** `WB_EN=1`, `ALU_res=0x2A`, `dest=3`, no memory op → `ready` stays 1; next cycle `WB_EN_out=1`, `ALU_res_out=0x2A`, `dest_out=3`.
- **Store then load:** store `val_rm=0xDEADBEEF` at 1028 → `ready` low for 3 cycles, high in the 4th. Load from 1028 → `mem_data_out=0xDEADBEEF` and `MEM_R_out=1` exactly 4 cycles after presentation; `WB_EN_out=0` during the 3 stall cycles.
- **Out of range:** store 0x55 at 1020 and at 1024+4·64 → no array change; loads of those addresses return 0, and word 0 is unchanged.
- **Back-to-back:** three consecutive loads → `ready` pattern 0001 0001 0001, with no gap cycles.
- **Reset mid-access:** assert `rst` in cycle 2 of a store to 1032 (array previously 0x11) → FSM in `IDLE`, outputs 0; a later load of 1032 returns 0x11.
- **Conflict and single-cycle:** `MEM_R=MEM_W=1` → write performed, `mem_data_out=0`. Rerun with `WAIT_CYCLES=1` → `ready` is constantly 1 and a load's data appears the next cycle.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared types and constants for the memory stage.
//   state_t       - memory-stage FSM states (IDLE, BUSY)
//   ADDR_BASE_DEF - default byte address that maps to data-memory word 0
package arm_pkg;
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EXE-to-MEM inputs and MEM/WB outputs of the memory stage.
//   master - upstream/testbench side: drives EXE results, reads ready and MEM/WB
//   slave  - mem_stage side
interface mem_stage_if;
   logic        WB_EN, MEM_R, MEM_W;
   logic [31:0] ALU_res, val_rm;
   logic [3:0]  dest;
   logic        ready, WB_EN_out, MEM_R_out;
   logic [31:0] ALU_res_out, mem_data_out;
   logic [3:0]  dest_out;
   modport master (output WB_EN, MEM_R, MEM_W, ALU_res, val_rm, dest,
                   input  ready, WB_EN_out, MEM_R_out, ALU_res_out, mem_data_out, dest_out);
   modport slave  (input  WB_EN, MEM_R, MEM_W, ALU_res, val_rm, dest,
                   output ready, WB_EN_out, MEM_R_out, ALU_res_out, mem_data_out, dest_out);
endinterface

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory, synchronous write, asynchronous read.
//   clk     - clock
//   we_i    - write enable (write lands at the clock edge)
//   addr_i  - byte address; word = (addr_i - ADDR_BASE) >> 2
//   wdata_i - write data
//   rdata_o - read data, 0 when the address is out of range
module data_mem import arm_pkg::*; #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF
) (
   input  logic        clk,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [31:0]   mem [DEPTH];
   logic [29:0]   word;
   logic [AW-1:0] idx;
   logic          in_range;
   // The full word offset is range-checked so that addresses beyond DEPTH never alias.
   assign word     = 30'((addr_i - ADDR_BASE) >> 2);
   assign idx      = word[AW-1:0];
   assign in_range = (addr_i >= ADDR_BASE) && ({2'b00, word} < 32'(DEPTH));
   assign rdata_o  = in_range ? mem[idx] : '0;
   always_ff @(posedge clk)
      if (we_i && in_range) mem[idx] <= wdata_i;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with multi-cycle data memory and MEM/WB register.
//   clk    - clock
//   rst    - asynchronous active-high reset
//   mem_io - EXE inputs, ready (upstream freeze = !ready) and registered MEM/WB outputs
module mem_stage import arm_pkg::*; #(
   parameter int          WAIT_CYCLES = 4,
   parameter int          DEPTH       = 64,
   parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.slave  mem_io
);
   state_t      state_q;
   logic [31:0] cnt_q, alu_q, data_q, rdata;
   logic [3:0]  dest_q;
   logic        wb_q, mr_q, ready;
   assign ready = (state_q == BUSY) ? (cnt_q == 32'(WAIT_CYCLES - 1))
                                    : !((mem_io.MEM_R | mem_io.MEM_W) && WAIT_CYCLES > 1);
   // Store lands on the edge ending the ready cycle; never while reset is held.
   data_mem #(.DEPTH(DEPTH), .ADDR_BASE(ADDR_BASE)) u_mem (
      .clk     (clk),
      .we_i    (mem_io.MEM_W & ready & ~rst),
      .addr_i  (mem_io.ALU_res),
      .wdata_i (mem_io.val_rm),
      .rdata_o (rdata)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wb_q    <= 1'b0;
         mr_q    <= 1'b0;
         alu_q   <= '0;
         data_q  <= '0;
         dest_q  <= '0;
      end else begin
         if (state_q == IDLE) begin
            if (!ready) begin
               state_q <= BUSY;
               cnt_q   <= 32'd1;
            end
         end else if (ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else cnt_q <= cnt_q + 32'd1;
         // Stall cycles capture a bubble so write-back fires only once per instruction.
         wb_q <= ready & mem_io.WB_EN;
         mr_q <= ready & mem_io.MEM_R;
         if (ready) begin
            alu_q  <= mem_io.ALU_res;
            dest_q <= mem_io.dest;
            data_q <= (mem_io.MEM_R & ~mem_io.MEM_W) ? rdata : '0;
         end
      end
   assign mem_io.ready        = ready;
   assign mem_io.WB_EN_out    = wb_q;
   assign mem_io.MEM_R_out    = mr_q;
   assign mem_io.ALU_res_out  = alu_q;
   assign mem_io.mem_data_out = data_q;
   assign mem_io.dest_out     = dest_q;
endmodule
